// File: rtl/clk_div_prog.sv
// clk_div_prog -- runtime-programmable clock divider for the watch timebase.
//
// Produces a registered divided clock with programmable period and high time,
// a one-cycle tick at each period start, and an independent free-running
// display-scan tick. New divisor settings are staged in a shadow register and
// only take effect at a period boundary, so the divided clock never glitches.
//
// Optional feature macro: CLK_DIV_BLINK_EN
//   defined   : blink toggles on every tick (half-rate square wave)
//   undefined : blink tied low, no toggle register
//
// Ports:
//   clk_in    in   system clock, all logic on rising edge
//   rst_n     in   synchronous reset, active low
//   en        in   count enable for the main divider (scan counter ignores it)
//   div_load  in   strobe: capture div_val/high_val into the shadow
//   div_val   in   requested period in clk_in cycles (clamped to >= 2)
//   high_val  in   requested high time (clamped to 1..period-1)
//   clk       out  divided clock
//   tick      out  one-cycle pulse at each period start
//   scan_tick out  one-cycle pulse every SCAN_DIV cycles
//   blink     out  half-rate blink (see macro above)
//   pending   out  a shadow load is waiting for the next wrap
module clk_div_prog #(
  parameter int WIDTH        = 27,
  parameter int DIV_DEFAULT  = 100000000,
  parameter int HIGH_DEFAULT = 50000000,
  parameter int SCAN_DIV     = 100000,
  parameter int SCAN_WIDTH   = 17
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_val,
  input  logic [WIDTH-1:0] high_val,
  output logic             clk,
  output logic             tick,
  output logic             scan_tick,
  output logic             blink,
  output logic             pending
);

  localparam logic [WIDTH-1:0]      ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0]      TWO       = WIDTH'(2);
  localparam logic [WIDTH-1:0]      PER_RST   = WIDTH'(DIV_DEFAULT);
  localparam logic [WIDTH-1:0]      HIGH_RST  = WIDTH'(HIGH_DEFAULT);
  localparam logic [SCAN_WIDTH-1:0] SCAN_LAST = SCAN_WIDTH'(SCAN_DIV - 1);
  localparam logic [SCAN_WIDTH-1:0] SCAN_ONE  = SCAN_WIDTH'(1);

  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      period_q, period_d;
  logic [WIDTH-1:0]      high_q, high_d;
  logic [WIDTH-1:0]      sh_per_q, sh_per_d;
  logic [WIDTH-1:0]      sh_high_q, sh_high_d;
  logic                  pending_q, pending_d;
  logic                  clk_q, clk_d;
  logic                  tick_q, tick_d;
  logic [SCAN_WIDTH-1:0] scan_cnt_q, scan_cnt_d;
  logic                  scan_tick_q, scan_tick_d;

  // Clamp at capture time so the shadow always holds a legal setting; the
  // result is identical to clamping when it is applied.
  logic [WIDTH-1:0] ld_per, ld_high_min, ld_high;
  always_comb begin
    ld_per      = (div_val < TWO) ? TWO : div_val;
    ld_high_min = (high_val == '0) ? ONE : high_val;
    ld_high     = (ld_high_min > ld_per - ONE) ? (ld_per - ONE) : ld_high_min;
  end

  logic             wrap, apply;
  logic [WIDTH-1:0] cnt_nxt, high_use;
  always_comb begin
    wrap     = (cnt_q == period_q - ONE);
    apply    = en && wrap && pending_q;
    cnt_nxt  = wrap ? '0 : cnt_q + ONE;
    // The first cycle of a freshly applied period must already use its high.
    high_use = apply ? sh_high_q : high_q;
  end

  always_comb begin
    cnt_d       = cnt_q;
    clk_d       = clk_q;
    tick_d      = 1'b0;
    period_d    = period_q;
    high_d      = high_q;
    sh_per_d    = sh_per_q;
    sh_high_d   = sh_high_q;
    pending_d   = pending_q;
    scan_cnt_d  = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + SCAN_ONE;
    scan_tick_d = (scan_cnt_q == SCAN_LAST);

    if (en) begin
      cnt_d  = cnt_nxt;
      clk_d  = (cnt_nxt < high_use);
      tick_d = wrap;
    end
    if (apply) begin
      period_d  = sh_per_q;
      high_d    = sh_high_q;
      pending_d = 1'b0;
    end
    // A load on the wrap edge is evaluated after the apply above, so it
    // survives as pending for the following period.
    if (div_load) begin
      sh_per_d  = ld_per;
      sh_high_d = ld_high;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      clk_q       <= 1'b0;
      tick_q      <= 1'b0;
      period_q    <= PER_RST;
      high_q      <= HIGH_RST;
      sh_per_q    <= PER_RST;
      sh_high_q   <= HIGH_RST;
      pending_q   <= 1'b0;
      scan_cnt_q  <= '0;
      scan_tick_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      clk_q       <= clk_d;
      tick_q      <= tick_d;
      period_q    <= period_d;
      high_q      <= high_d;
      sh_per_q    <= sh_per_d;
      sh_high_q   <= sh_high_d;
      pending_q   <= pending_d;
      scan_cnt_q  <= scan_cnt_d;
      scan_tick_q <= scan_tick_d;
    end
  end

`ifdef CLK_DIV_BLINK_EN
  logic blink_q, blink_d;
  always_comb blink_d = blink_q ^ (en && wrap);
  always_ff @(posedge clk_in) begin
    if (!rst_n) blink_q <= 1'b0;
    else        blink_q <= blink_d;
  end
  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

  assign clk       = clk_q;
  assign tick      = tick_q;
  assign scan_tick = scan_tick_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog with a small configuration
// (period 4, high 2, scan every 3 cycles). A behavioural model tracks the
// position within the current period and applies staged settings at period
// boundaries; directed scenarios also check fixed expected sequences.
module tb_clk_div_prog;
  localparam int W = 8, DIVD = 4, HIGHD = 2, SD = 3, SW = 2;

  logic         clk_in = 1'b0;
  logic         rst_n, en, div_load;
  logic [W-1:0] div_val, high_val;
  logic         clk, tick, scan_tick, blink, pending;

  int vectors = 0;
  int errors  = 0;

  // model state
  int m_pos, m_per, m_high, m_shp, m_shh, m_edges;
  bit m_pend, m_clk, m_tick, m_stick, m_blink;

  clk_div_prog #(
    .WIDTH(W), .DIV_DEFAULT(DIVD), .HIGH_DEFAULT(HIGHD),
    .SCAN_DIV(SD), .SCAN_WIDTH(SW)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .div_load(div_load),
    .div_val(div_val), .high_val(high_val), .clk(clk), .tick(tick),
    .scan_tick(scan_tick), .blink(blink), .pending(pending)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout want completion");
    $fatal(1);
  end

  // One rising edge; the model consumes the inputs present at that edge.
  task automatic advance();
    bit applied;
    int np, nh;
    applied = 0;
    @(posedge clk_in);
    if (!rst_n) begin
      m_pos = 0; m_per = DIVD; m_high = HIGHD; m_shp = DIVD; m_shh = HIGHD;
      m_pend = 0; m_clk = 0; m_tick = 0; m_stick = 0; m_blink = 0; m_edges = 0;
    end else begin
      m_edges++;
      m_stick = (m_edges % SD) == 0;
      m_tick  = 0;
      if (en) begin
        if (m_pos + 1 >= m_per) begin
          m_pos = 0; m_tick = 1; m_blink = !m_blink;
          if (m_pend) begin m_per = m_shp; m_high = m_shh; applied = 1; end
        end else m_pos++;
        m_clk = m_pos < m_high;
      end
      if (applied) m_pend = 0;
      if (div_load) begin
        np = int'(div_val); nh = int'(high_val);
        if (np < 2) np = 2;
        if (nh < 1) nh = 1;
        if (nh > np - 1) nh = np - 1;
        m_shp = np; m_shh = nh; m_pend = 1;
      end
    end
    #1;
  endtask

  function automatic logic [4:0] exp_vec();
`ifdef CLK_DIV_BLINK_EN
    return {m_clk, m_tick, m_stick, m_blink, m_pend};
`else
    return {m_clk, m_tick, m_stick, 1'b0, m_pend};
`endif
  endfunction

  function automatic logic [4:0] act_vec();
    return {clk, tick, scan_tick, blink, pending};
  endfunction

  task automatic do_reset();
    rst_n = 0; en = 0; div_load = 0; div_val = '0; high_val = '0;
    advance();
    rst_n = 1;
  endtask

  task automatic test_reset();
    bit clk_tbl [8] = '{1, 0, 0, 1, 1, 0, 0, 1};
    logic [3:0] want;
    bit bl;
    rst_n = 0; en = 1; div_load = 0; div_val = '0; high_val = '0;
    advance();
    vectors++;
    if (act_vec() !== 5'b0) begin
      errors++; $display("FAIL reset_state: got %b want 00000", act_vec());
    end
    rst_n = 1;
    for (int e = 1; e <= 8; e++) begin
      advance();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_model edge %0d: got %b want %b", e, act_vec(), exp_vec());
      end
`ifdef CLK_DIV_BLINK_EN
      bl = (e >= 4 && e < 8);
`else
      bl = 0;
`endif
      want = {clk_tbl[e-1], (e % 4) == 0, (e % 3) == 0, bl};
      vectors++;
      if ({clk, tick, scan_tick, blink} !== want) begin
        errors++; $display("FAIL reset_seq edge %0d: got %b want %b", e, {clk, tick, scan_tick, blink}, want);
      end
    end
  endtask

  task automatic test_enable_hold();
    do_reset();
    en = 1;
    for (int e = 1; e <= 5; e++) begin
      advance(); vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL hold_pre edge %0d: got %b want %b", e, act_vec(), exp_vec());
      end
    end
    en = 0;
    for (int e = 6; e <= 8; e++) begin
      advance(); vectors++;
      if ({clk, tick, scan_tick} !== {1'b1, 1'b0, e == 6} || act_vec() !== exp_vec()) begin
        errors++; $display("FAIL hold_off edge %0d: got %b want clk1 tick0 scan%0d model %b", e, act_vec(), e == 6, exp_vec());
      end
    end
    en = 1;
    for (int k = 1; k <= 3; k++) begin
      advance(); vectors++;
      if (tick !== (k == 3) || act_vec() !== exp_vec()) begin
        errors++; $display("FAIL hold_resume step %0d: got %b want tick %0d model %b", k, act_vec(), k == 3, exp_vec());
      end
    end
  endtask

  // Waits (bounded) for the tick at which a pending load is applied.
  task automatic wait_apply(input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      advance(); vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL %s_wait: got %b want %b", name, act_vec(), exp_vec());
      end
      if (tick === 1'b1 && pending === 1'b0) ok = 1;
    end
    if (!ok) begin
      errors++; $display("FAIL %s_timeout: got no applying tick want one within 20 edges", name);
    end
  endtask

  task automatic test_reprogram();
    bit ok;
    do_reset();
    en = 1;
    advance();
    div_load = 1; div_val = 8'd6; high_val = 8'd4;
    advance();
    div_load = 0;
    vectors++;
    if (pending !== 1'b1 || act_vec() !== exp_vec()) begin
      errors++; $display("FAIL reprog_pending: got %b want pending 1 model %b", act_vec(), exp_vec());
    end
    wait_apply("reprog", ok);
    vectors++;
    if (clk !== 1'b1) begin
      errors++; $display("FAIL reprog_first_clk: got %b want 1", clk);
    end
    for (int k = 1; k <= 11; k++) begin
      advance(); vectors++;
      if ({clk, tick} !== {(k % 6) < 4, (k % 6) == 0} || act_vec() !== exp_vec()) begin
        errors++; $display("FAIL reprog_seq k %0d: got %b want clk %0d tick %0d", k, act_vec(), (k % 6) < 4, (k % 6) == 0);
      end
    end
  endtask

  task automatic test_clamp();
    bit ok;
    do_reset();
    en = 1;
    div_load = 1; div_val = 8'd1; high_val = 8'd0;
    advance();
    div_load = 0;
    wait_apply("clamp_lo", ok);
    for (int k = 1; k <= 6; k++) begin
      advance(); vectors++;
      if ({clk, tick} !== {(k % 2) == 0, (k % 2) == 0} || act_vec() !== exp_vec()) begin
        errors++; $display("FAIL clamp_lo k %0d: got %b want clk %0d", k, act_vec(), (k % 2) == 0);
      end
    end
    div_load = 1; div_val = 8'd5; high_val = 8'd9;
    advance();
    div_load = 0;
    wait_apply("clamp_hi", ok);
    for (int k = 1; k <= 10; k++) begin
      advance(); vectors++;
      if ({clk, tick} !== {(k % 5) < 4, (k % 5) == 0} || act_vec() !== exp_vec()) begin
        errors++; $display("FAIL clamp_hi k %0d: got %b want clk %0d tick %0d", k, act_vec(), (k % 5) < 4, (k % 5) == 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    en = 1;
    for (int e = 1; e <= 3; e++) advance();
    div_load = 1; div_val = 8'd6; high_val = 8'd4;
    advance();   // edge 4: wrap coincides with the load
    div_load = 0;
    vectors++;
    if ({tick, pending, clk} !== 3'b111 || act_vec() !== exp_vec()) begin
      errors++; $display("FAIL wrapload_edge: got %b want tick1 pending1 clk1", act_vec());
    end
    for (int e = 5; e <= 14; e++) begin
      advance(); vectors++;
      if (tick !== (e == 8 || e == 14) || pending !== (e < 8) || act_vec() !== exp_vec()) begin
        errors++; $display("FAIL wrapload_seq edge %0d: got %b want tick %0d pending %0d", e, act_vec(), e == 8 || e == 14, e < 8);
      end
    end
    advance(); advance();   // cnt = 2 in the new 6-cycle period
    rst_n = 0;
    advance();
    vectors++;
    if (act_vec() !== 5'b0 || act_vec() !== exp_vec()) begin
      errors++; $display("FAIL midreset_state: got %b want 00000", act_vec());
    end
    rst_n = 1;
    for (int e = 1; e <= 4; e++) begin
      advance(); vectors++;
      if (tick !== (e == 4) || act_vec() !== exp_vec()) begin
        errors++; $display("FAIL midreset_period edge %0d: got %b want tick %0d", e, act_vec(), e == 4);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      en       = ($urandom_range(0, 3) != 0);
      div_load = ($urandom_range(0, 11) == 0);
      div_val  = W'($urandom_range(0, 9));
      high_val = W'($urandom_range(0, 11));
      advance(); vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL random iter %0d: got %b want %b", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_enable_hold();
    test_reprogram();
    test_clamp();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
